decim_stream_ctrl: RTL and testbench

//  Sequencer and output buffer for the CIC/FIR/halfband decimation chain (total R=128).

---
 rtl/decim_pkg.sv | 13 +
 rtl/decim_sync_fifo.sv | 66 ++++++
 rtl/decim_stream_ctrl.sv | 145 ++++++++++++++
 tb/tb_decim_stream_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decim_pkg.sv
// Shared definitions for the decimation-chain sequencer: FSM state encoding and default widths.
package decim_pkg;

  localparam int DATA_WIDTH_DEF = 50;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

endpackage

// File: rtl/decim_sync_fifo.sv
// Small synchronous FIFO with flop storage. The head entry is driven straight from flops,
// so a push into an empty FIFO is visible on dout right after the pushing edge.
module decim_sync_fifo #(
  parameter int DATA_WIDTH = 50,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [LW-1:0]         level
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push_ok && !clr) mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/decim_stream_ctrl.sv
// Sequencer for the decimation chain: holds it in reset (flush), discards warm-up samples
// (settle), then buffers chain output into a FIFO for a ready/valid consumer.
module decim_stream_ctrl
  import decim_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH     = 8,
  parameter int FLUSH_CYCLES   = 16,
  parameter int SETTLE_SAMPLES = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        mod_in_valid,
  output logic                        chain_rst_n,
  output logic                        chain_in_valid,
  input  logic                        chain_out_valid,
  input  logic [DATA_WIDTH-1:0]       chain_out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overrun,
  input  logic                        clr_overrun,
  output logic [1:0]                  state,
  output logic [CNT_WIDTH-1:0]        sample_count
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam int SCW = $clog2(SETTLE_SAMPLES + 2);

  state_e               state_q, state_d;
  logic [FCW-1:0]       flush_cnt_q, flush_cnt_d;
  logic [SCW-1:0]       settle_cnt_q, settle_cnt_d;
  logic [CNT_WIDTH-1:0] sample_count_q, sample_count_d;
  logic                 overrun_q, overrun_d;
  logic                 chain_rst_n_q, chain_rst_n_d;

  logic fifo_full;
  logic fifo_empty;
  logic push_req;
  logic pop_req;
  logic push_accepted;
  logic push_dropped;
  logic run_entry;

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        flush_cnt_d  = '0;
        settle_cnt_d = '0;
        if (enable) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FCW'(FLUSH_CYCLES - 1)) begin
          flush_cnt_d  = '0;
          settle_cnt_d = '0;
          state_d      = (SETTLE_SAMPLES == 0) ? ST_RUN : ST_SETTLE;
        end else begin
          flush_cnt_d = flush_cnt_q + FCW'(1);
        end
      end
      ST_SETTLE: begin
        if (chain_out_valid) begin
          if (settle_cnt_q == SCW'(SETTLE_SAMPLES - 1)) begin
            settle_cnt_d = '0;
            state_d      = ST_RUN;
          end else begin
            settle_cnt_d = settle_cnt_q + SCW'(1);
          end
        end
      end
      default: ;
    endcase
    if (!enable) begin
      state_d      = ST_IDLE;
      flush_cnt_d  = '0;
      settle_cnt_d = '0;
    end
  end

  assign run_entry      = (state_d == ST_RUN) && (state_q != ST_RUN);
  assign chain_in_valid = mod_in_valid & ((state_q == ST_SETTLE) | (state_q == ST_RUN));
  // Registered from the next state so the chain sees a clean reset edge aligned with state.
  assign chain_rst_n_d  = (state_d == ST_SETTLE) || (state_d == ST_RUN);

  assign push_req      = enable & (state_q == ST_RUN) & chain_out_valid;
  assign pop_req       = out_ready & ~fifo_empty;
  assign push_accepted = push_req & (~fifo_full | pop_req);
  assign push_dropped  = push_req & fifo_full & ~pop_req;

  always_comb begin
    sample_count_d = sample_count_q;
    if (!enable || state_q == ST_IDLE || run_entry) sample_count_d = '0;
    else if (push_accepted) sample_count_d = sample_count_q + CNT_WIDTH'(1);
    overrun_d = overrun_q;
    if (clr_overrun)       overrun_d = 1'b0;
    else if (push_dropped) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      flush_cnt_q    <= '0;
      settle_cnt_q   <= '0;
      sample_count_q <= '0;
      overrun_q      <= 1'b0;
      chain_rst_n_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      sample_count_q <= sample_count_d;
      overrun_q      <= overrun_d;
      chain_rst_n_q  <= chain_rst_n_d;
    end
  end

  decim_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (~enable),
    .push  (push_req),
    .pop   (out_ready),
    .din   (chain_out_data),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_valid    = ~fifo_empty;
  assign chain_rst_n  = chain_rst_n_q;
  assign overrun      = overrun_q;
  assign state        = state_q;
  assign sample_count = sample_count_q;

endmodule

// File: tb/tb_decim_stream_ctrl.sv
// Bench for decim_stream_ctrl: directed sequencing checks, a vector table for FIFO
// full/overrun corners, random traffic against a queue model, and a SETTLE_SAMPLES=0 instance.
module tb_decim_stream_ctrl;

  localparam int DW = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0, mod_in_valid = 1'b0, cov = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic [DW-1:0] cod = '0;
  logic          chain_rst_n, chain_in_valid, out_valid, overrun;
  logic [DW-1:0] out_data;
  logic [3:0]    fifo_level;
  logic [1:0]    state;
  logic [15:0]   sample_count;

  logic          enable_b = 1'b0, cov_b = 1'b0, rdy_b = 1'b0;
  logic          chain_rst_n_b, chain_in_valid_b, out_valid_b, overrun_b;
  logic [DW-1:0] out_data_b;
  logic [3:0]    fifo_level_b;
  logic [1:0]    state_b;
  logic [3:0]    sample_count_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decim_stream_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .mod_in_valid(mod_in_valid),
    .chain_rst_n(chain_rst_n), .chain_in_valid(chain_in_valid),
    .chain_out_valid(cov), .chain_out_data(cod), .out_valid(out_valid),
    .out_ready(rdy), .out_data(out_data), .fifo_level(fifo_level),
    .overrun(overrun), .clr_overrun(clr), .state(state), .sample_count(sample_count)
  );

  decim_stream_ctrl #(.SETTLE_SAMPLES(0), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .enable(enable_b), .mod_in_valid(mod_in_valid),
    .chain_rst_n(chain_rst_n_b), .chain_in_valid(chain_in_valid_b),
    .chain_out_valid(cov_b), .chain_out_data(cod), .out_valid(out_valid_b),
    .out_ready(rdy_b), .out_data(out_data_b), .fifo_level(fifo_level_b),
    .overrun(overrun_b), .clr_overrun(clr), .state(state_b), .sample_count(sample_count_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] val(input int i);
    return 50'h3_0000_0000_0000 | (50'(i + 1) * 50'h100_0001);
  endfunction

  typedef struct {
    logic          cov;
    logic [DW-1:0] data;
    logic          rdy;
    logic          clr;
    logic          ev;
    logic          cd;
    logic [DW-1:0] ed;
    int            el;
    logic          eo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic c, input logic [DW-1:0] d, input logic r, input logic cl,
                              input logic ev, input logic cd, input logic [DW-1:0] ed,
                              input int el, input logic eo);
    vec_t v;
    v = '{cov: c, data: d, rdy: r, clr: cl, ev: ev, cd: cd, ed: ed, el: el, eo: eo};
    tbl.push_back(v);
  endfunction

  // Reference model for RUN-state traffic: FIFO contents, sticky overrun, accepted count.
  logic [DW-1:0] m_q[$];
  logic          m_ovr = 1'b0;
  int            m_cnt = 0;

  task automatic step(input logic c, input logic [DW-1:0] d, input logic r, input logic cl);
    bit do_pop, acc, drop;
    cov = c; cod = d; rdy = r; clr = cl;
    do_pop = (m_q.size() > 0) && r;
    acc    = c && ((m_q.size() < 8) || do_pop);
    drop   = c && !acc;
    if (do_pop) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back(d);
      m_cnt++;
    end
    if (cl) m_ovr = 1'b0;
    else if (drop) m_ovr = 1'b1;
    tick();
    chk("mdl_valid", 64'(out_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) chk("mdl_data", 64'(out_data), 64'(m_q[0]));
    chk("mdl_level", 64'(fifo_level), 64'(m_q.size()));
    chk("mdl_overrun", 64'(overrun), 64'(m_ovr));
    chk("mdl_count", 64'(sample_count), 64'(16'(m_cnt)));
  endtask

  initial begin
    logic [DW-1:0] smin, smax, ones;
    smin = 50'h2_0000_0000_0000;
    smax = 50'h1_FFFF_FFFF_FFFF;
    ones = '1;

    // Reset state
    tick(); tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_chain_rst_n", 64'(chain_rst_n), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_count", 64'(sample_count), 64'd0);
    chk("rst_state_b", 64'(state_b), 64'd0);

    // Flush: 16 cycles in FLUSH with chain held in reset; a chain pulse here is ignored
    rst = 1'b0; enable = 1'b1; mod_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cov = (i == 5);
      tick();
      chk("flush_state", 64'(state), 64'd1);
      chk("flush_rst_n", 64'(chain_rst_n), 64'd0);
      chk("flush_in_valid", 64'(chain_in_valid), 64'd0);
    end
    cov = 1'b0;
    tick();
    chk("settle_state", 64'(state), 64'd2);
    chk("settle_rst_n", 64'(chain_rst_n), 64'd1);
    chk("settle_in_valid", 64'(chain_in_valid), 64'd1);

    // Settle: eight dropped samples, RUN entered on the eighth
    for (int k = 0; k < 8; k++) begin
      cov = 1'b1; cod = val(100 + k);
      tick();
      chk("settle_pulse_state", 64'(state), (k < 7) ? 64'd2 : 64'd3);
      chk("settle_level", 64'(fifo_level), 64'd0);
      cov = 1'b0;
      tick();
    end
    chk("run_state", 64'(state), 64'd3);
    chk("run_count0", 64'(sample_count), 64'd0);
    chk("run_valid0", 64'(out_valid), 64'd0);

    // Pass-through of boundary values with consumer always ready
    rdy = 1'b1;
    cov = 1'b1; cod = 50'h1; tick();
    chk("pt_valid_1", 64'(out_valid), 64'd1);
    chk("pt_data_1", 64'(out_data), 64'h1);
    cod = smin; tick();
    chk("pt_data_min", 64'(out_data), 64'(smin));
    chk("pt_level_min", 64'(fifo_level), 64'd1);
    cod = smax; tick();
    chk("pt_data_max", 64'(out_data), 64'(smax));
    cod = ones; tick();
    chk("pt_data_ones", 64'(out_data), 64'(ones));
    cov = 1'b0; tick();
    chk("pt_valid_end", 64'(out_valid), 64'd0);
    chk("pt_count", 64'(sample_count), 64'd4);

    // Vector table: overrun with ninth push lost, clear, then full with simultaneous push/pop
    for (int i = 0; i < 9; i++)
      add(1'b1, val(i), 1'b0, 1'b0, 1'b1, 1'b1, val(0), (i < 8) ? i + 1 : 8, i == 8);
    for (int i = 0; i < 8; i++)
      add(1'b0, '0, 1'b1, 1'b0, i < 7, i < 7, (i < 7) ? val(i + 1) : '0, 7 - i, 1'b1);
    add(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      add(1'b1, val(10 + i), 1'b0, 1'b0, 1'b1, 1'b1, val(10), i + 1, 1'b0);
    add(1'b1, val(30), 1'b0, 1'b1, 1'b1, 1'b1, val(10), 8, 1'b0);
    add(1'b1, val(20), 1'b1, 1'b0, 1'b1, 1'b1, val(11), 8, 1'b0);
    for (int j = 0; j < 8; j++)
      add(1'b0, '0, 1'b1, 1'b0, j < 7, j < 7,
          (j < 6) ? val(12 + j) : ((j == 6) ? val(20) : '0), 7 - j, 1'b0);

    foreach (tbl[n]) begin
      cov = tbl[n].cov; cod = tbl[n].data; rdy = tbl[n].rdy; clr = tbl[n].clr;
      tick();
      chk($sformatf("tbl%0d_valid", n), 64'(out_valid), 64'(tbl[n].ev));
      if (tbl[n].cd) chk($sformatf("tbl%0d_data", n), 64'(out_data), 64'(tbl[n].ed));
      chk($sformatf("tbl%0d_level", n), 64'(fifo_level), 64'(tbl[n].el));
      chk($sformatf("tbl%0d_overrun", n), 64'(overrun), 64'(tbl[n].eo));
    end
    cov = 1'b0; clr = 1'b0;
    chk("tbl_count", 64'(sample_count), 64'd21);

    // Random traffic against the queue model
    m_cnt = 21;
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), {18'($urandom), $urandom},
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

    // Force overrun, drain, leave five entries, then drop enable
    for (int i = 0; i < 9; i++) step(1'b1, val(50 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, val(40 + i), 1'b0, 1'b0);
    chk("pre_stop_level", 64'(fifo_level), 64'd5);
    enable = 1'b0; cov = 1'b0;
    tick();
    chk("stop_state", 64'(state), 64'd0);
    chk("stop_valid", 64'(out_valid), 64'd0);
    chk("stop_level", 64'(fifo_level), 64'd0);
    chk("stop_rst_n", 64'(chain_rst_n), 64'd0);
    chk("stop_count", 64'(sample_count), 64'd0);
    chk("stop_overrun_kept", 64'(overrun), 64'(m_ovr));
    chk("stop_in_valid", 64'(chain_in_valid), 64'd0);

    // SETTLE_SAMPLES=0 instance: FLUSH straight to RUN, 4-bit count wraps
    enable_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("b_flush_state", 64'(state_b), 64'd1);
    end
    tick();
    chk("b_run_state", 64'(state_b), 64'd3);
    chk("b_run_rst_n", 64'(chain_rst_n_b), 64'd1);
    rdy_b = 1'b1; cov_b = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cod = val(200 + i);
      tick();
    end
    cov_b = 1'b0;
    chk("b_count_wrap", 64'(sample_count_b), 64'd1);
    chk("b_data_last", 64'(out_data_b), 64'(val(216)));
    tick();
    chk("b_valid_end", 64'(out_valid_b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
